// File: rtl/ecp5pll_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase-adjust controller.
package ecp5pll_pkg;
    localparam int PHASE_POS_W = 10;
    localparam int PLL_NOUT    = 4;

    typedef logic [1:0] phase_ch_t;

    typedef enum logic [2:0] {
        IDLE, LOCKWAIT, SETUP, STEP, GAP, LOAD, DONE
    } phase_state_t;
endpackage

// File: rtl/phase_pos_cnt.sv
// Wrapping up/down phase position counter for one PLL output; clear wins over stepping.
module phase_pos_cnt
    import ecp5pll_pkg::*;
#(
    parameter int WRAP = 40
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_up,
    input  logic                   i_dn,
    input  logic                   i_clr,
    output logic [PHASE_POS_W-1:0] o_pos
);
    localparam logic [PHASE_POS_W-1:0] LAST = PHASE_POS_W'(WRAP - 1);

    logic [PHASE_POS_W-1:0] r_pos;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pos <= '0;
        else if (i_clr)
            r_pos <= '0;
        else if (i_up)
            r_pos <= (r_pos == LAST) ? '0 : r_pos + 1'b1;
        else if (i_dn)
            r_pos <= (r_pos == '0) ? LAST : r_pos - 1'b1;
    end

    assign o_pos = r_pos;
endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequencer for the ECP5 PLL phase-adjust port: spaced step pulses, lock waits, register loads.
// Optional ECP5PLL_PHASE_POS_EN adds per-channel position counters on pos_o.
module ecp5pll_phase_ctrl
    import ecp5pll_pkg::*;
#(
    parameter int setup_cyc = 2,
    parameter int step_hold = 4,
    parameter int gap_cyc   = 4,
    parameter int pos_wrap  = 40
) (
    input  logic       clk_i,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_load,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_count,
    input  logic       locked,
    output logic [1:0] phasesel,
    output logic       phasedir,
    output logic       phasestep,
    output logic       phaseloadreg,
    output logic       busy,
    output logic       done
`ifdef ECP5PLL_PHASE_POS_EN
    ,output logic [PLL_NOUT*PHASE_POS_W-1:0] pos_o
`endif
);
    localparam logic [15:0] SETUP_LAST = 16'(setup_cyc - 1);
    localparam logic [15:0] STEP_LAST  = 16'(step_hold - 1);
    localparam logic [15:0] GAP_LAST   = 16'(gap_cyc - 1);

    phase_state_t r_state, w_next;
    logic [15:0]  r_tmr;
    logic [7:0]   r_rem;
    phase_ch_t    r_sel;
    logic         r_dir, r_load;
    logic         r_phasestep, r_phaseloadreg, r_busy, r_done;
    logic         w_step_end;

    assign w_step_end = (r_state == STEP) && (r_tmr == STEP_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (req_valid) w_next = LOCKWAIT;
            LOCKWAIT: if (locked) begin
                          if (r_load)             w_next = LOAD;
                          else if (r_rem == 8'd0) w_next = DONE;
                          else                    w_next = SETUP;
                      end
            SETUP:    if (r_tmr == SETUP_LAST) w_next = STEP;
            STEP:     if (r_tmr == STEP_LAST)  w_next = GAP;
            // lock is only sampled here so a pulse in flight is never cut short
            GAP:      if (r_tmr == GAP_LAST) begin
                          if (r_rem == 8'd0) w_next = DONE;
                          else if (!locked)  w_next = LOCKWAIT;
                          else               w_next = STEP;
                      end
            LOAD:     if (r_tmr == STEP_LAST) w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Outputs are registered from w_next so the PLL pins see clean, glitch-free levels.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_tmr          <= '0;
            r_rem          <= '0;
            r_sel          <= '0;
            r_dir          <= 1'b0;
            r_load         <= 1'b0;
            r_phasestep    <= 1'b0;
            r_phaseloadreg <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_tmr          <= (w_next != r_state) ? 16'd0 : r_tmr + 16'd1;
            r_phasestep    <= (w_next == STEP);
            r_phaseloadreg <= (w_next == LOAD);
            r_busy         <= (w_next != IDLE);
            r_done         <= (w_next == DONE);
            if (r_state == IDLE && req_valid) begin
                r_sel  <= req_sel;
                r_dir  <= req_dir;
                r_rem  <= req_count;
                r_load <= req_load;
            end else if (w_step_end) begin
                r_rem <= r_rem - 8'd1;
            end
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign phasesel     = r_sel;
    assign phasedir     = r_dir;
    assign phasestep    = r_phasestep;
    assign phaseloadreg = r_phaseloadreg;
    assign busy         = r_busy;
    assign done         = r_done;

`ifdef ECP5PLL_PHASE_POS_EN
    logic w_load_end;
    assign w_load_end = (r_state == LOAD) && (r_tmr == STEP_LAST);

    for (genvar k = 0; k < PLL_NOUT; k++) begin : g_pos
        logic w_hit;
        assign w_hit = (r_sel == phase_ch_t'(k));
        phase_pos_cnt #(.WRAP(pos_wrap)) u_pos (
            .i_clk   (clk_i),
            .i_rst_n (reset_n),
            .i_up    (w_step_end && w_hit && !r_dir),
            .i_dn    (w_step_end && w_hit && r_dir),
            .i_clr   (w_load_end && w_hit),
            .o_pos   (pos_o[k*PHASE_POS_W +: PHASE_POS_W])
        );
    end
`endif
endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed bench for ecp5pll_phase_ctrl with default timing parameters.
module tb_ecp5pll_phase_ctrl;
    logic       clk_i = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0, req_load = 1'b0, req_dir = 1'b0, locked = 1'b1;
    logic [1:0] req_sel = '0;
    logic [7:0] req_count = '0;
    logic       req_ready, phasedir, phasestep, phaseloadreg, busy, done;
    logic [1:0] phasesel;
`ifdef ECP5PLL_PHASE_POS_EN
    logic [39:0] pos_o;
`endif

    ecp5pll_phase_ctrl dut (
        .clk_i(clk_i), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_sel(req_sel), .req_dir(req_dir), .req_count(req_count),
        .locked(locked), .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
        .phaseloadreg(phaseloadreg), .busy(busy), .done(done)
`ifdef ECP5PLL_PHASE_POS_EN
        , .pos_o(pos_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int acc;
    int rises[$];
    int dones[$];
    int hi_cyc, ld_cyc, ld_first;
    logic prev_ps = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Activity recorded at the falling edge, away from the DUT's active edge.
    always @(negedge clk_i) begin
        if (phasestep && !prev_ps) rises.push_back(cyc);
        if (phasestep) hi_cyc++;
        prev_ps = phasestep;
        if (done) dones.push_back(cyc);
        if (phaseloadreg) begin
            if (ld_cyc == 0) ld_first = cyc;
            ld_cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        rises.delete();
        dones.delete();
        hi_cyc = 0;
        ld_cyc = 0;
        ld_first = -1;
    endtask

    task automatic send(input logic [1:0] sel, input logic dir, input logic [7:0] cnt, input logic ld);
        int n = 0;
        @(negedge clk_i);
        while (!req_ready && n < 50) begin @(negedge clk_i); n++; end
        if (!req_ready) chk("ready_timeout", 0, 1);
        clr_stats();
        req_valid = 1'b1; req_sel = sel; req_dir = dir; req_count = cnt; req_load = ld;
        @(posedge clk_i); #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (dones.size() == 0 && n < budget) begin @(negedge clk_i); n++; end
        if (dones.size() == 0) chk("done_timeout", 0, 1);
        repeat (4) @(negedge clk_i);
    endtask

    initial begin
        clr_stats();
        // reset state
        repeat (3) @(negedge clk_i);
        chk("rst_phasestep", phasestep, 0);
        chk("rst_loadreg", phaseloadreg, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_phasesel", phasesel, 0);
        reset_n = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", req_ready, 1);

        // three up-steps on channel 1
        send(2'd1, 1'b0, 8'd3, 1'b0);
        @(negedge clk_i);
        chk("t1_phasesel", phasesel, 1);
        chk("t1_phasedir", phasedir, 0);
        chk("t1_busy", busy, 1);
        chk("t1_ready", req_ready, 0);
        wait_done(100);
        chk("t1_nrise", rises.size(), 3);
        chk("t1_first", rises.size() > 0 ? rises[0] - acc : -1, 3);
        chk("t1_space", rises.size() > 2 ? rises[2] - rises[1] : -1, 8);
        chk("t1_hi", hi_cyc, 12);
        chk("t1_ndone", dones.size(), 1);
        chk("t1_done_at", dones.size() > 0 ? dones[0] - acc : -1, 27);
        chk("t1_sel_hold", phasesel, 1);
`ifdef ECP5PLL_PHASE_POS_EN
        chk("t1_pos1", pos_o[19:10], 3);
`endif

        // one down-step on channel 2 wraps 0 -> 39
        send(2'd2, 1'b1, 8'd1, 1'b0);
        wait_done(60);
        chk("t2_dir", phasedir, 1);
        chk("t2_nrise", rises.size(), 1);
`ifdef ECP5PLL_PHASE_POS_EN
        chk("t2_pos2", pos_o[29:20], 39);
`endif

        // zero count: done with no pulses
        send(2'd0, 1'b0, 8'd0, 1'b0);
        wait_done(20);
        chk("t3_nrise", rises.size(), 0);
        chk("t3_done_at", dones.size() > 0 ? dones[0] - acc : -1, 1);

        // 45 up-steps on channel 0 wraps at 40
        send(2'd0, 1'b0, 8'd45, 1'b0);
        wait_done(500);
        chk("t4_nrise", rises.size(), 45);
        chk("t4_done_at", dones.size() > 0 ? dones[0] - acc : -1, 3 + 45 * 8);
`ifdef ECP5PLL_PHASE_POS_EN
        chk("t4_pos0", pos_o[9:0], 5);
`endif

        // lock lost during the 2nd pulse, restored 20 cycles later
        send(2'd0, 1'b0, 8'd4, 1'b0);
        do begin @(posedge clk_i); #1; end while (cyc < acc + 12);
        locked = 1'b0;
        @(negedge clk_i);
        chk("t5_pulse_cont", phasestep, 1);
        repeat (19) @(negedge clk_i);
        chk("t5_wait_busy", busy, 1);
        chk("t5_wait_nostep", phasestep, 0);
        chk("t5_rises_held", rises.size(), 2);
        locked = 1'b1;
        wait_done(100);
        chk("t5_nrise", rises.size(), 4);
        chk("t5_hi", hi_cyc, 16);
        chk("t5_ndone", dones.size(), 1);
`ifdef ECP5PLL_PHASE_POS_EN
        chk("t5_pos0", pos_o[9:0], 9);
`endif

        // step channel 3, ignoring a request raised while busy, then load it
        send(2'd3, 1'b0, 8'd2, 1'b0);
        req_valid = 1'b1; req_sel = 2'd0; req_dir = 1'b1;
        repeat (3) @(negedge clk_i);
        req_valid = 1'b0;
        chk("t6_busy_sel", phasesel, 3);
        chk("t6_busy_dir", phasedir, 0);
        wait_done(60);
`ifdef ECP5PLL_PHASE_POS_EN
        chk("t6_pos3_pre", pos_o[39:30], 2);
`endif
        send(2'd3, 1'b0, 8'd9, 1'b1);
        wait_done(30);
        chk("t6_ld_cyc", ld_cyc, 4);
        chk("t6_ld_first", ld_first - acc, 1);
        chk("t6_done_at", dones.size() > 0 ? dones[0] - acc : -1, 5);
        chk("t6_nrise", rises.size(), 0);
`ifdef ECP5PLL_PHASE_POS_EN
        chk("t6_pos3", pos_o[39:30], 0);
        chk("t6_pos1", pos_o[19:10], 3);
`endif

        // asynchronous reset mid-pulse
        send(2'd1, 1'b0, 8'd2, 1'b0);
        begin
            int n = 0;
            while (!phasestep && n < 20) begin @(negedge clk_i); n++; end
        end
        chk("t7_in_step", phasestep, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t7_rst_step", phasestep, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_sel", phasesel, 0);
`ifdef ECP5PLL_PHASE_POS_EN
        chk("t7_rst_pos", pos_o, 0);
`endif
        @(negedge clk_i);
        reset_n = 1'b1;
        @(negedge clk_i);
        chk("t7_ready", req_ready, 1);
        chk("t7_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
